// File: rtl/riscv_reorder_buffer_mp_if.sv
// Handshake bundle between the issue/writeback/commit pipeline and the
// multi-port reorder buffer. The ROB sits on the slave side.
interface riscv_reorder_buffer_mp_if #(
  parameter int SLOT_BITS = 5,
  parameter int REG_BITS  = 5,
  parameter int ALLOC_W   = 2,
  parameter int FILL_W    = 2,
  parameter int COMMIT_W  = 2
);
  // issue-side allocation
  logic [ALLOC_W-1:0]           alloc_val;
  logic [ALLOC_W-1:0]           alloc_wen;
  logic [ALLOC_W*REG_BITS-1:0]  alloc_waddr;
  logic                         alloc_rdy;
  logic [ALLOC_W*SLOT_BITS-1:0] alloc_slot;
  // writeback completion
  logic [FILL_W-1:0]            fill_val;
  logic [FILL_W*SLOT_BITS-1:0]  fill_slot;
  // mispredict squash
  logic                         flush_val;
  logic [SLOT_BITS-1:0]         flush_slot;
  // in-order retirement
  logic [COMMIT_W-1:0]          commit_wen;
  logic [COMMIT_W-1:0]          commit_val;
  logic [COMMIT_W*SLOT_BITS-1:0] commit_slot;
  logic [COMMIT_W*REG_BITS-1:0] commit_waddr;
  // status
  logic [SLOT_BITS:0]           count;
  logic                         empty;
  logic                         fill_err;

  modport master (
    output alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot, flush_val, flush_slot,
    input  alloc_rdy, alloc_slot, commit_wen, commit_val, commit_slot, commit_waddr,
           count, empty, fill_err
  );

  modport slave (
    input  alloc_val, alloc_wen, alloc_waddr, fill_val, fill_slot, flush_val, flush_slot,
    output alloc_rdy, alloc_slot, commit_wen, commit_val, commit_slot, commit_waddr,
           count, empty, fill_err
  );
endinterface

// File: rtl/riscv_reorder_buffer_mp.sv
// Multi-port reorder buffer: in-order allocation on ALLOC_W lanes, out-of-order
// completion on FILL_W ports, in-order retirement on COMMIT_W lanes, plus
// mispredict squash of everything younger than a surviving slot.
module riscv_reorder_buffer_mp #(
  parameter int DEPTH     = 32,
  parameter int SLOT_BITS = 5,
  parameter int REG_BITS  = 5,
  parameter int ALLOC_W   = 2,
  parameter int FILL_W    = 2,
  parameter int COMMIT_W  = 2
) (
  input logic clk,
  input logic reset,
  riscv_reorder_buffer_mp_if.slave rob
);
  localparam int PTR_W = SLOT_BITS + 1;

  typedef enum logic [1:0] {
    ST_FREE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_READY   = 2'd2
  } state_e;

  // registered state
  state_e               state_q [DEPTH];
  state_e               state_d [DEPTH];
  logic                 wen_q   [DEPTH];
  logic                 wen_d   [DEPTH];
  logic [REG_BITS-1:0]  waddr_q [DEPTH];
  logic [REG_BITS-1:0]  waddr_d [DEPTH];
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic                 fill_err_q, fill_err_d;

  // occupancy derived from the wrap-bit pointers
  logic [PTR_W-1:0]     count;
  logic [PTR_W:0]       free_cnt;
  logic [SLOT_BITS-1:0] head_idx;

  assign count    = tail_q - head_q;
  assign free_cnt = (PTR_W+1)'(DEPTH) - {1'b0, count};
  assign head_idx = head_q[SLOT_BITS-1:0];

  assign rob.count    = count;
  assign rob.empty    = (count == '0);
  assign rob.fill_err = fill_err_q;

  // flush: offset of the surviving slot from head decides liveness
  logic [SLOT_BITS-1:0] flush_off;
  logic                 flush_live;
  logic [DEPTH-1:0]     squash;

  assign flush_off  = rob.flush_slot - head_idx;
  assign flush_live = rob.flush_val && ({1'b0, flush_off} < count);

  // allocation: registered-count credit check, blocked by any flush request
  logic                 alloc_fire;
  logic [PTR_W-1:0]     lane_off  [0:ALLOC_W];
  logic [SLOT_BITS-1:0] alloc_idx [ALLOC_W];

  assign rob.alloc_rdy = (free_cnt >= (PTR_W+1)'(ALLOC_W)) && !rob.flush_val;
  assign alloc_fire    = rob.alloc_rdy && (|rob.alloc_val);
  assign lane_off[0]   = '0;

  genvar gi;
  generate
    // enabled lanes pack onto consecutive slots starting at tail
    for (gi = 0; gi < ALLOC_W; gi++) begin : g_alloc
      assign lane_off[gi+1] = lane_off[gi] + PTR_W'(rob.alloc_val[gi]);
      assign alloc_idx[gi]  = tail_q[SLOT_BITS-1:0] + lane_off[gi][SLOT_BITS-1:0];
      assign rob.alloc_slot[gi*SLOT_BITS +: SLOT_BITS] = alloc_idx[gi];
    end

    // an entry is squashed when it lies after the surviving slot but is still live
    for (gi = 0; gi < DEPTH; gi++) begin : g_squash
      logic [SLOT_BITS-1:0] rel;
      assign rel        = SLOT_BITS'(gi) - head_idx;
      assign squash[gi] = flush_live && (rel > flush_off) && ({1'b0, rel} < count);
    end
  endgenerate

  // commit: a lane retires only if every older lane does and its entry is READY.
  // Lanes beyond a same-cycle surviving flush slot are held back so a squashed
  // instruction can never retire.
  logic [COMMIT_W:0]    cmt_chain;
  logic [SLOT_BITS-1:0] cmt_idx [COMMIT_W];

  assign cmt_chain[0] = 1'b1;

  generate
    for (gi = 0; gi < COMMIT_W; gi++) begin : g_commit
      logic lane_ok;
      assign cmt_idx[gi]   = head_idx + SLOT_BITS'(gi);
      assign lane_ok       = (PTR_W'(gi) < count) && (state_q[cmt_idx[gi]] == ST_READY) &&
                             !(flush_live && (SLOT_BITS'(gi) > flush_off));
      assign cmt_chain[gi+1] = cmt_chain[gi] && lane_ok;
      assign rob.commit_val[gi] = cmt_chain[gi+1];
      assign rob.commit_wen[gi] = cmt_chain[gi+1] && wen_q[cmt_idx[gi]];
      assign rob.commit_slot[gi*SLOT_BITS +: SLOT_BITS] = cmt_idx[gi];
      assign rob.commit_waddr[gi*REG_BITS +: REG_BITS]  = waddr_q[cmt_idx[gi]];
    end
  endgenerate

  // next-state: fills, then commit frees, then allocation, squash has final say
  always_comb begin
    logic [SLOT_BITS-1:0] fidx;
    logic [PTR_W-1:0]     n_commit;
    fidx       = '0;
    n_commit   = '0;
    fill_err_d = fill_err_q;
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      wen_d[i]   = wen_q[i];
      waddr_d[i] = waddr_q[i];
    end

    for (int p = 0; p < FILL_W; p++) begin
      if (rob.fill_val[p]) begin
        fidx = rob.fill_slot[p*SLOT_BITS +: SLOT_BITS];
        if (!squash[fidx]) begin
          if (state_q[fidx] == ST_PENDING) state_d[fidx] = ST_READY;
          else                             fill_err_d    = 1'b1;
        end
      end
    end

    for (int k = 0; k < COMMIT_W; k++) begin
      if (rob.commit_val[k]) begin
        state_d[cmt_idx[k]] = ST_FREE;
        n_commit = n_commit + PTR_W'(1);
      end
    end

    for (int j = 0; j < ALLOC_W; j++) begin
      if (alloc_fire && rob.alloc_val[j]) begin
        state_d[alloc_idx[j]] = ST_PENDING;
        wen_d[alloc_idx[j]]   = rob.alloc_wen[j];
        waddr_d[alloc_idx[j]] = rob.alloc_waddr[j*REG_BITS +: REG_BITS];
      end
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (squash[i]) state_d[i] = ST_FREE;
    end

    head_d = head_q + n_commit;
    if (flush_live)      tail_d = head_q + {1'b0, flush_off} + PTR_W'(1);
    else if (alloc_fire) tail_d = tail_q + lane_off[ALLOC_W];
    else                 tail_d = tail_q;
  end

  // state registers, cleared asynchronously while reset is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_FREE;
        wen_q[i]   <= 1'b0;
        waddr_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      fill_err_q <= fill_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= state_d[i];
        wen_q[i]   <= wen_d[i];
        waddr_q[i] <= waddr_d[i];
      end
    end
  end
endmodule

// File: doc/riscv_reorder_buffer_mp.md
Name: riscv_reorder_buffer_mp

Overview:
Parametrised multi-port reorder buffer for the wide-issue RISCV core.
- Allocates ROB slots in program order at issue.
- Marks slots complete on writeback fill ports.
- Retires completed entries in order through COMMIT_W commit ports to the register file.
- Adds branch-mispredict squash (flush of younger entries) and occupancy/credit outputs, which the fixed two-port ROB lacks.

Parameters:
DEPTH, 32, number of entries; power of two, >= 4
SLOT_BITS, 5, log2(DEPTH)
REG_BITS, 5, architectural register address width
ALLOC_W, 2, allocation (issue) lanes
FILL_W, 2, writeback fill ports
COMMIT_W, 2, commit ports per cycle

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state while low
alloc_val  in  ALLOC_W  per-lane allocation request
alloc_wen  in  ALLOC_W  lane instruction writes a register
alloc_waddr  in  ALLOC_W*REG_BITS  destination register per lane
alloc_rdy  out  1  free entries >= ALLOC_W and flush_val low
alloc_slot  out  ALLOC_W*SLOT_BITS  slot assigned per lane (combinational)
fill_val  in  FILL_W  writeback complete
fill_slot  in  FILL_W*SLOT_BITS  slot being completed
flush_val  in  1  squash request
flush_slot  in  SLOT_BITS  oldest surviving slot; everything younger is squashed
commit_wen  out  COMMIT_W  commit lane retires a register-writing entry
commit_val  out  COMMIT_W  commit lane retires an entry
commit_slot  out  COMMIT_W*SLOT_BITS  retiring slot
commit_waddr  out  COMMIT_W*REG_BITS  retiring destination register
count  out  SLOT_BITS+1  live entries
empty  out  1  count == 0
fill_err  out  1  sticky: fill to a non-PENDING slot

Behaviour:
Entry state:
- Each entry holds state FREE/PENDING/READY, plus wen and waddr.
- head and tail are SLOT_BITS+1-bit pointers; the extra bit is the wrap bit.
- count = tail - head, modulo 2^(SLOT_BITS+1).

Reset (reset low, asynchronous):
- head = tail = 0; all entries FREE; fill_err = 0.
- Outputs: count = 0, empty = 1, alloc_rdy = 1, commit_val = commit_wen = 0.

Allocation:
- Fires when alloc_rdy && any alloc_val bit is set.
- Enabled lanes are packed in lane order: lane i gets slot tail + popcount(alloc_val[i-1:0]).
- Each allocated entry becomes PENDING with its lane's wen/waddr; tail advances by popcount(alloc_val).
- alloc_slot is valid in the same cycle as the request.
- Requests made while alloc_rdy is low are ignored, with no partial allocation.

Fill:
- A fill_slot in PENDING becomes READY at the clock edge.
- A fill to a FREE or READY slot is ignored and sets fill_err.
- Two fill ports naming the same PENDING slot: the slot becomes READY once; no error.

Commit:
- Combinational from registered state.
- Lane k is valid iff k < count and entries head..head+k are all READY; commit stops at the first non-READY entry.
- Committed entries go FREE at the edge; head advances by the number of valid lanes.
- Minimum latency: fill at edge N, commit_val visible in cycle N+1.

Flush:
- If flush_slot is live (between head and tail-1), entries flush_slot+1 .. tail-1 go FREE and tail = flush_slot+1.
- A non-live flush_slot is ignored.
- Same-cycle interactions:
  - Commits of older entries proceed.
  - Fills to squashed slots are discarded with no error.
  - Allocation is blocked.

Boundaries:
- Full (count == DEPTH): commit may free entries in the same cycle, but alloc_rdy uses the registered count, so there is no same-cycle reuse.
- Pointer wrap is modulo 2^(SLOT_BITS+1).
- Simultaneous alloc and commit update head and tail independently.
- Reset asserted mid-operation discards all entries immediately.

Test Plan:
1. Reset, then allocate lanes {1,1} with waddr 3/7, wen 1/1 -> alloc_slot 0/1; count 2; fill slot 1 then slot 0 -> nothing commits until slot 0 is READY; the cycle after, commit_val = 2'b11, slots 0/1, waddr 3/7; count 0.
2. Allocate with only lane 1 valid -> lane 1 gets slot 0 (packed); tail = 1.
3. Fill 32 entries (DEPTH = 32) -> alloc_rdy = 0 at count 31 (fewer than 2 free); count reaches 32 via a single-lane allocate is not possible, so verify alloc_rdy low at count 31 and a request there is ignored; commit 2, then allocate 2 -> slots 31 and 0 with the wrap bit toggled.
4. Slots 4..9 live; flush_slot = 6 while filling 8 -> tail = 7; slots 7..9 FREE; fill_err stays 0; count 3.
5. Fill a FREE slot 20 -> fill_err = 1 and stays 1 until reset; state is otherwise unchanged.
6. Assert reset low mid-commit with 5 entries live -> outputs clear asynchronously; after release, count 0, empty 1, and next alloc_slot is 0.
